// File: rtl/gppcu_pipe_ctrl.sv
// gppcu_pipe_ctrl
//   Fetch/issue controller that sits in front of the GPPCU thread lanes. It owns the PC and
//   reads instructions from a synchronous instruction memory. The external decoder turns
//   each fetched word into a control word (CW). The CW and the instruction word then shift
//   through the DEC, EXEC and WB stage registers that every lane consumes.
//   The whole pipe freezes while any lane reports a multi-cycle busy. When a HALT reaches
//   fetch, the pipe drains and then pulses done.
//
// Ports
//   iACLK, inRST            clock, synchronous active-low reset
//   iSTART, iSTART_PC       launch pulse (honoured only in idle) and first fetch address
//   oRUNNING, oDONE         busy-running flag (run or drain), 1-cycle completion pulse
//   oIMEM_ADDR, oIMEM_RD    instruction memory address (registered PC) and read enable
//   iIMEM_RDATA             memory read data, valid the cycle after a read
//   oINSTR_FCH, iFCH_CW     fetch-stage instruction to the decoder, decoded CW back
//   iBUSY                   OR of all lane busy flags, used as the stall request
//   oCW_*, oINSTR_*         DEC/EXEC/WB stage control words and instructions
module gppcu_pipe_ctrl #(
  parameter int unsigned PCW         = 10,
  parameter int unsigned CW_BITS     = 32,
  parameter int unsigned CW_HALT_BIT = 31
) (
  input  logic               iACLK,
  input  logic               inRST,
  input  logic               iSTART,
  input  logic [PCW-1:0]     iSTART_PC,
  output logic               oRUNNING,
  output logic               oDONE,
  output logic [PCW-1:0]     oIMEM_ADDR,
  output logic               oIMEM_RD,
  input  logic [31:0]        iIMEM_RDATA,
  output logic [31:0]        oINSTR_FCH,
  input  logic [CW_BITS-1:0] iFCH_CW,
  input  logic               iBUSY,
  output logic [CW_BITS-1:0] oCW_DEC,
  output logic [CW_BITS-1:0] oCW_EXEC,
  output logic [CW_BITS-1:0] oCW_WB,
  output logic [31:0]        oINSTR_DEC,
  output logic [31:0]        oINSTR_EXEC,
  output logic [31:0]        oINSTR_WB
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [PCW-1:0]     pc_q, pc_d;
  logic               fch_valid_q, fch_valid_d;
  logic [CW_BITS-1:0] cw_dec_q, cw_dec_d;
  logic [CW_BITS-1:0] cw_exec_q, cw_exec_d;
  logic [CW_BITS-1:0] cw_wb_q, cw_wb_d;
  logic [31:0]        instr_dec_q, instr_dec_d;
  logic [31:0]        instr_exec_q, instr_exec_d;
  logic [31:0]        instr_wb_q, instr_wb_d;

  logic stall;
  logic in_run;
  logic imem_rd;
  logic halt;
  logic dec_valid;
  logic pipe_empty;
  logic [CW_BITS-1:0] dec_cw_in;

  assign stall      = iBUSY;
  assign in_run     = (state_q == StRun);
  assign imem_rd    = in_run & ~stall;
  // HALT is consumed in fetch: it never issues, and it stops further fetching.
  assign halt       = fch_valid_q & iFCH_CW[CW_HALT_BIT] & ~stall & in_run;
  assign dec_valid  = fch_valid_q & ~halt & in_run;
  assign dec_cw_in  = dec_valid ? (iFCH_CW | CW_BITS'(1)) : '0;
  assign pipe_empty = ~(cw_dec_q[0] | cw_exec_q[0] | cw_wb_q[0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (iSTART) state_d = StRun;
      StRun:   if (halt) state_d = StDrain;
      // A stall freezes DEC/EXEC, so completion is only judged on a moving cycle.
      StDrain: if (pipe_empty && !stall) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (state_q == StIdle && iSTART) begin
      pc_d = iSTART_PC;
    end else if (imem_rd) begin
      pc_d = pc_q + PCW'(1);
    end
  end

  assign fch_valid_d = stall ? fch_valid_q : (imem_rd & ~halt);

  always_comb begin
    cw_dec_d     = cw_dec_q;
    instr_dec_d  = instr_dec_q;
    cw_exec_d    = cw_exec_q;
    instr_exec_d = instr_exec_q;
    // While stalled WB receives a bubble so the held EXEC op retires only once.
    cw_wb_d      = '0;
    instr_wb_d   = instr_exec_q;
    if (!stall) begin
      cw_dec_d     = dec_cw_in;
      instr_dec_d  = iIMEM_RDATA;
      cw_exec_d    = cw_dec_q;
      instr_exec_d = instr_dec_q;
      cw_wb_d      = cw_exec_q;
    end
  end

  always_ff @(posedge iACLK) begin
    if (!inRST) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      fch_valid_q  <= 1'b0;
      cw_dec_q     <= '0;
      cw_exec_q    <= '0;
      cw_wb_q      <= '0;
      instr_dec_q  <= '0;
      instr_exec_q <= '0;
      instr_wb_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fch_valid_q  <= fch_valid_d;
      cw_dec_q     <= cw_dec_d;
      cw_exec_q    <= cw_exec_d;
      cw_wb_q      <= cw_wb_d;
      instr_dec_q  <= instr_dec_d;
      instr_exec_q <= instr_exec_d;
      instr_wb_q   <= instr_wb_d;
    end
  end

  assign oRUNNING    = (state_q == StRun) | (state_q == StDrain);
  assign oDONE       = (state_q == StDone);
  assign oIMEM_ADDR  = pc_q;
  assign oIMEM_RD    = imem_rd;
  assign oINSTR_FCH  = iIMEM_RDATA;
  assign oCW_DEC     = cw_dec_q;
  assign oCW_EXEC    = cw_exec_q;
  assign oCW_WB      = cw_wb_q;
  assign oINSTR_DEC  = instr_dec_q;
  assign oINSTR_EXEC = instr_exec_q;
  assign oINSTR_WB   = instr_wb_q;

endmodule
